// File: rtl/rd_ddr_pkg.sv
// rd_ddr_pkg: shared FSM encoding and DDR/AXI geometry constants for the read port.
// Contents: state_e (IDLE/ADDR/DATA/DONE), beat size in bytes and as a shift, 4 KB AXI boundary.
package rd_ddr_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_e;
    localparam int BEAT_BYTES  = 64;
    localparam int BEAT_SHIFT  = 6;
    localparam int BOUNDARY_4K = 4096;
endpackage

// File: rtl/rd_ddr_burst_split.sv
// rd_ddr_burst_split: sizes the next AXI read burst.
// Ports: i_off  - current byte offset inside the queue region
//        i_rem  - beats still owed to the request
//        o_len  - AXI arlen (burst beats - 1)
// Burst = min(remaining, max burst, beats to next 4 KB line, beats to region end).
module rd_ddr_burst_split
    import rd_ddr_pkg::*;
#(
    parameter int          AW             = 32,
    parameter logic [31:0] P_QUEUE_REGION = 32'h0008_0000,
    parameter int          P_MAX_BURST    = 64
) (
    input  logic [AW-1:0] i_off,
    input  logic [AW-1:0] i_rem,
    output logic [7:0]    o_len
);
    localparam logic [AW-1:0] REGION = AW'(P_QUEUE_REGION);
    localparam logic [AW-1:0] MAXB   = AW'(P_MAX_BURST);
    localparam logic [AW-1:0] B4K    = AW'(BOUNDARY_4K);
    logic [AW-1:0] to_4k, to_reg, m0, m1, size;
    always_comb begin
        to_4k  = (B4K - (i_off & (B4K - AW'(1)))) >> BEAT_SHIFT;
        to_reg = (REGION - i_off) >> BEAT_SHIFT;
        m0     = (i_rem < MAXB) ? i_rem : MAXB;
        m1     = (to_4k < to_reg) ? to_4k : to_reg;
        size   = (m0 < m1) ? m0 : m1;
        o_len  = 8'(size - AW'(1));
    end
endmodule

// File: rtl/rd_ddr_port_exec.sv
// rd_ddr_port_exec: turns (queue, byte count) read requests into AXI read bursts over per-queue DDR regions.
// Ports: i_clk/i_rst_n           - clock, async active-low reset
//        i_rd_*                  - request (flag, queue, bytes, valid) / o_rd_byte_ready accept
//        o_rd_queue_finish       - one-cycle pulse when a request completes
//        o_m_axi_ar* / i_m_axi_r*- AXI read address and data channels (one burst outstanding)
//        o_rd_data*              - read beats passed through with latched flag/queue, last on final beat
//        o_err                   - sticky flag for a request naming an unused queue
module rd_ddr_port_exec
    import rd_ddr_pkg::*;
#(
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 512,
    parameter int          P_DDR_LOCAL_QUEUE  = 4,
    parameter int          P_QUEUE_NUM        = 8,
    parameter logic [31:0] P_QUEUE_REGION     = 32'h0008_0000,
    parameter int          P_MAX_BURST        = 64
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rd_flag,
    input  logic [P_DDR_LOCAL_QUEUE-1:0]  i_rd_queue,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_rd_byte,
    input  logic                          i_rd_byte_valid,
    output logic                          o_rd_byte_ready,
    output logic                          o_rd_queue_finish,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] o_m_axi_araddr,
    output logic [7:0]                    o_m_axi_arlen,
    output logic                          o_m_axi_arvalid,
    input  logic                          i_m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] i_m_axi_rdata,
    input  logic                          i_m_axi_rvalid,
    input  logic                          i_m_axi_rlast,
    output logic                          o_m_axi_rready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] o_rd_data,
    output logic                          o_rd_data_valid,
    output logic                          o_rd_data_last,
    output logic                          o_rd_data_flag,
    output logic [P_DDR_LOCAL_QUEUE-1:0]  o_rd_data_queue,
    input  logic                          i_rd_data_ready,
    output logic                          o_err
);
    localparam int              AW       = C_M_AXI_ADDR_WIDTH;
    localparam int              QW       = P_DDR_LOCAL_QUEUE;
    localparam int              QMAX     = 1 << QW;
    localparam int              RSH      = $clog2(P_QUEUE_REGION);
    localparam logic [AW-1:0]   OFF_MASK = AW'(P_QUEUE_REGION - 32'd1);
    localparam logic [AW-1:0]   BEAT     = AW'(BEAT_BYTES);

    state_e        state_q, state_d;
    logic [QW-1:0] queue_q, queue_d;
    logic          flag_q, flag_d, err_q, err_d, run_q, run_d;
    logic [AW-1:0] rem_q, rem_d;
    // Sized to the full queue field so any queue value indexes safely; unused entries stay 0.
    logic [AW-1:0] off_q [QMAX];
    logic [AW-1:0] off_d [QMAX];
    logic [AW-1:0] cur_off, beats;
    logic [7:0]    len;
    logic          in_data, beat_acc;

    assign cur_off = off_q[queue_q];
    assign beats   = (i_rd_byte >> BEAT_SHIFT) + AW'(|i_rd_byte[BEAT_SHIFT-1:0]);
    assign in_data = (state_q == S_DATA);
    assign beat_acc = in_data && i_m_axi_rvalid && i_rd_data_ready;

    rd_ddr_burst_split #(
        .AW             (AW),
        .P_QUEUE_REGION (P_QUEUE_REGION),
        .P_MAX_BURST    (P_MAX_BURST)
    ) u_split (
        .i_off (cur_off),
        .i_rem (rem_q),
        .o_len (len)
    );

    always_comb begin
        state_d = state_q;
        queue_d = queue_q;
        flag_d  = flag_q;
        err_d   = err_q;
        rem_d   = rem_q;
        off_d   = off_q;
        run_d   = 1'b1;
        case (state_q)
            S_IDLE: if (run_q && i_rd_byte_valid) begin
                queue_d = i_rd_queue;
                flag_d  = i_rd_flag;
                rem_d   = beats;
                if (int'(i_rd_queue) >= P_QUEUE_NUM) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = (beats == '0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: state_d = i_m_axi_arready ? S_DATA : S_ADDR;
            S_DATA: if (beat_acc) begin
                rem_d          = rem_q - AW'(1);
                off_d[queue_q] = (cur_off + BEAT) & OFF_MASK;
                if (i_m_axi_rlast)
                    state_d = (rem_q == AW'(1)) ? S_DONE : S_ADDR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            queue_q <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
            rem_q   <= '0;
            run_q   <= 1'b0;
            for (int i = 0; i < QMAX; i++) off_q[i] <= '0;
        end else begin
            state_q <= state_d;
            queue_q <= queue_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
            rem_q   <= rem_d;
            run_q   <= run_d;
            off_q   <= off_d;
        end
    end

    // run_q keeps the request port closed until the first clock after reset release.
    assign o_rd_byte_ready   = (state_q == S_IDLE) && run_q;
    assign o_rd_queue_finish = (state_q == S_DONE);
    assign o_m_axi_arvalid   = (state_q == S_ADDR);
    assign o_m_axi_araddr    = o_m_axi_arvalid ? ((AW'(queue_q) << RSH) | cur_off) : '0;
    assign o_m_axi_arlen     = o_m_axi_arvalid ? len : 8'd0;
    assign o_m_axi_rready    = in_data && i_rd_data_ready;
    assign o_rd_data_valid   = in_data && i_m_axi_rvalid;
    assign o_rd_data         = in_data ? i_m_axi_rdata : '0;
    assign o_rd_data_last    = o_rd_data_valid && (rem_q == AW'(1));
    assign o_rd_data_flag    = flag_q;
    assign o_rd_data_queue   = queue_q;
    assign o_err             = err_q;
endmodule

// File: tb/tb_rd_ddr_port_exec.sv
// tb_rd_ddr_port_exec: directed scoreboard bench for rd_ddr_port_exec with a simple AXI read slave.
module tb_rd_ddr_port_exec;
    localparam int AW = 32;
    localparam int DW = 512;
    localparam int QW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rd_flag = 1'b0;
    logic [QW-1:0] rd_queue = '0;
    logic [AW-1:0] rd_byte = '0;
    logic          rd_valid = 1'b0;
    logic          byte_ready, finish;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic          arvalid;
    logic          arready = 1'b1;
    logic [DW-1:0] rdata = '0;
    logic          rvalid = 1'b0;
    logic          rlast = 1'b0;
    logic          rready;
    logic [DW-1:0] d_data;
    logic          d_valid, d_last, d_flag;
    logic [QW-1:0] d_queue;
    logic          d_ready = 1'b1;
    logic          err;

    always #5 clk = ~clk;

    rd_ddr_port_exec dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_rd_flag         (rd_flag),
        .i_rd_queue        (rd_queue),
        .i_rd_byte         (rd_byte),
        .i_rd_byte_valid   (rd_valid),
        .o_rd_byte_ready   (byte_ready),
        .o_rd_queue_finish (finish),
        .o_m_axi_araddr    (araddr),
        .o_m_axi_arlen     (arlen),
        .o_m_axi_arvalid   (arvalid),
        .i_m_axi_arready   (arready),
        .i_m_axi_rdata     (rdata),
        .i_m_axi_rvalid    (rvalid),
        .i_m_axi_rlast     (rlast),
        .o_m_axi_rready    (rready),
        .o_rd_data         (d_data),
        .o_rd_data_valid   (d_valid),
        .o_rd_data_last    (d_last),
        .o_rd_data_flag    (d_flag),
        .o_rd_data_queue   (d_queue),
        .i_rd_data_ready   (d_ready),
        .o_err             (err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } ar_t;
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          flag;
        logic [QW-1:0] q;
    } beat_t;

    ar_t   exp_ar[$];
    beat_t exp_beat[$];
    int    exp_fin[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    ev_cyc = 0;
    int    beats_seen = 0;

    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {448'd0, ~a, a};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    task automatic exp_burst(input logic [AW-1:0] a, input logic [7:0] l, input logic fin,
                             input logic f, input logic [QW-1:0] q);
        ar_t   e;
        beat_t b;
        e.addr = a;
        e.len  = l;
        exp_ar.push_back(e);
        for (int k = 0; k <= int'(l); k++) begin
            b.data = pat(a + 32'(64 * k));
            b.last = fin && (k == int'(l));
            b.flag = f;
            b.q    = q;
            exp_beat.push_back(b);
        end
    endtask

    // AXI slave: accepts every AR, returns len+1 beats whose data encodes the beat address.
    initial begin : slave
        ar_t sl_q[$];
        ar_t a;
        int  sl_beat;
        bit  acc_ar, acc_r;
        sl_beat = 0;
        forever begin
            @(negedge clk);
            acc_ar = arvalid && arready;
            a.addr = araddr;
            a.len  = arlen;
            acc_r  = rvalid && rready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                sl_q.delete();
                sl_beat = 0;
            end else begin
                if (acc_r && sl_q.size() > 0) begin
                    if (sl_beat == int'(sl_q[0].len)) begin
                        void'(sl_q.pop_front());
                        sl_beat = 0;
                    end else sl_beat++;
                end
                if (acc_ar) sl_q.push_back(a);
            end
            if (sl_q.size() > 0) begin
                rvalid = 1'b1;
                rdata  = pat(sl_q[0].addr + 32'(64 * sl_beat));
                rlast  = (sl_beat == int'(sl_q[0].len));
            end else begin
                rvalid = 1'b0;
                rdata  = '0;
                rlast  = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents AR, data or finish.
    initial begin : monitor
        ar_t   e;
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rd_valid && byte_ready) ev_cyc = cyc;
                if (arvalid && arready) begin
                    if (exp_ar.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL ar_unexpected: got addr %0h len %0d expected none", araddr, arlen);
                    end else begin
                        e = exp_ar.pop_front();
                        check("ar_addr", DW'(araddr), DW'(e.addr));
                        check("ar_len", DW'(arlen), DW'(e.len));
                    end
                end
                if (d_valid && d_ready) begin
                    beats_seen++;
                    if (exp_beat.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL beat_unexpected: got data %0h expected none", d_data);
                    end else begin
                        b = exp_beat.pop_front();
                        check("beat_data", d_data, b.data);
                        check("beat_last", DW'(d_last), DW'(b.last));
                        check("beat_flag", DW'(d_flag), DW'(b.flag));
                        check("beat_queue", DW'(d_queue), DW'(b.q));
                    end
                    if (d_last) ev_cyc = cyc;
                end
                if (!d_ready) check("rready_gated", DW'(rready), DW'(0));
                if (finish) begin
                    if (exp_fin.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL fin_unexpected: got finish at cycle %0d expected none", cyc);
                    end else begin
                        void'(exp_fin.pop_front());
                        check("fin_timing", DW'(cyc), DW'(ev_cyc + 1));
                    end
                end
            end
        end
    end

    task automatic send(input logic [QW-1:0] q, input logic [AW-1:0] n, input logic f);
        bit got;
        got      = 1'b0;
        rd_queue = q;
        rd_byte  = n;
        rd_flag  = f;
        rd_valid = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            got = byte_ready;
        end
        if (!got) fail_now("req_accept_timeout");
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int t = 0; t < budget && !done; t++) begin
            @(negedge clk);
            done = exp_ar.size() == 0 && exp_beat.size() == 0 && exp_fin.size() == 0 && byte_ready;
        end
        if (!done) begin
            $display("FAIL idle_timeout: ar=%0d beats=%0d fin=%0d left", exp_ar.size(), exp_beat.size(), exp_fin.size());
            total++;
            bad++;
            exp_ar.delete();
            exp_beat.delete();
            exp_fin.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int n);
        int t0;
        t0 = beats_seen;
        for (int t = 0; t < 200 && beats_seen < t0 + n; t++) @(negedge clk);
        if (beats_seen < t0 + n) fail_now("beat_wait_timeout");
    endtask

    initial begin : stim
        rst_n = 1'b0;
        #1;
        check("rst_byte_ready", DW'(byte_ready), DW'(0));
        check("rst_arvalid", DW'(arvalid), DW'(0));
        check("rst_finish", DW'(finish), DW'(0));
        check("rst_err", DW'(err), DW'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_clk", DW'(byte_ready), DW'(0));
        @(posedge clk);
        #1;
        check("ready_after_clk", DW'(byte_ready), DW'(1));

        // queue 2, 256 B: one 4-beat burst, then queue 2 continues at offset 0x100
        exp_burst(32'h0010_0000, 8'd3, 1'b1, 1'b1, 4'd2);
        exp_fin.push_back(1);
        send(4'd2, 32'd256, 1'b1);
        wait_idle(200);
        exp_burst(32'h0010_0100, 8'd0, 1'b1, 1'b0, 4'd2);
        exp_fin.push_back(1);
        send(4'd2, 32'd64, 1'b0);
        wait_idle(200);

        // queue 0, 5000 B = 79 beats split at the 4 KB line
        exp_burst(32'h0000_0000, 8'd63, 1'b0, 1'b0, 4'd0);
        exp_burst(32'h0000_1000, 8'd14, 1'b1, 1'b0, 4'd0);
        exp_fin.push_back(1);
        send(4'd0, 32'd5000, 1'b0);
        wait_idle(400);

        // walk queue 1 to offset 0x7FFC0, then cross the region end
        for (int k = 0; k < 127; k++) exp_burst(32'h0008_0000 + 32'(k * 4096), 8'd63, 1'b0, 1'b1, 4'd1);
        exp_burst(32'h000F_F000, 8'd62, 1'b1, 1'b1, 4'd1);
        exp_fin.push_back(1);
        send(4'd1, 32'h0007_FFC0, 1'b1);
        wait_idle(20000);
        exp_burst(32'h000F_FFC0, 8'd0, 1'b0, 1'b0, 4'd1);
        exp_burst(32'h0008_0000, 8'd0, 1'b1, 1'b0, 4'd1);
        exp_fin.push_back(1);
        send(4'd1, 32'd128, 1'b0);
        wait_idle(200);
        exp_burst(32'h0008_0040, 8'd0, 1'b1, 1'b0, 4'd1);
        exp_fin.push_back(1);
        send(4'd1, 32'd64, 1'b0);
        wait_idle(200);

        // zero-byte request: no AR, finish on the next cycle
        exp_fin.push_back(1);
        send(4'd3, 32'd0, 1'b0);
        wait_idle(200);

        // queue 4, 512 B with a stray valid during the burst and a 10-cycle downstream stall
        exp_burst(32'h0020_0000, 8'd7, 1'b1, 1'b1, 4'd4);
        exp_fin.push_back(1);
        send(4'd4, 32'd512, 1'b1);
        rd_valid = 1'b1;
        rd_byte  = 32'd64;
        wait_beats(3);
        @(posedge clk);
        #1;
        rd_valid = 1'b0;
        d_ready  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        d_ready = 1'b1;
        wait_idle(200);

        // illegal queue: sticky error, no AR
        exp_fin.push_back(1);
        send(4'd9, 32'd64, 1'b0);
        wait_idle(200);
        check("err_sticky", DW'(err), DW'(1));

        // reset in the middle of a data burst
        exp_burst(32'h0030_0000, 8'd9, 1'b1, 1'b0, 4'd6);
        exp_fin.push_back(1);
        send(4'd6, 32'd640, 1'b0);
        wait_beats(2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", DW'(d_valid), DW'(0));
        check("midrst_rready", DW'(rready), DW'(0));
        check("midrst_data", d_data, DW'(0));
        check("midrst_arvalid", DW'(arvalid), DW'(0));
        check("midrst_byte_ready", DW'(byte_ready), DW'(0));
        check("midrst_err", DW'(err), DW'(0));
        check("midrst_queue", DW'(d_queue), DW'(0));
        exp_ar.delete();
        exp_beat.delete();
        exp_fin.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_burst(32'h0028_0000, 8'd0, 1'b1, 1'b0, 4'd5);
        exp_fin.push_back(1);
        send(4'd5, 32'd64, 1'b0);
        wait_idle(200);
        exp_burst(32'h0010_0000, 8'd0, 1'b1, 1'b1, 4'd2);
        exp_fin.push_back(1);
        send(4'd2, 32'd64, 1'b1);
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rd_ddr_port_exec.md
RD_DDR_PORT_EXEC -- requirements
Module: rd_ddr_port_exec

Interface
REQ-001 SHALL have parameters: C_M_AXI_ADDR_WIDTH, default 32, address/byte-count width; C_M_AXI_DATA_WIDTH, default 512, beat width (64 B/beat); P_DDR_LOCAL_QUEUE, default 4, queue field width; P_QUEUE_NUM, default 8, queues in use; P_QUEUE_REGION, default 32'h0008_0000, bytes per queue region (power of two, 4 KB multiple); P_MAX_BURST, default 64, max beats per AXI burst.
REQ-002 SHALL have ports (name, direction, width, meaning):
i_clk  in  1  single clock
i_rst_n  in  1  reset, asynchronous, active-low
i_rd_flag  in  1  request tag, forwarded on data
i_rd_queue  in  P_DDR_LOCAL_QUEUE  queue to read
i_rd_byte  in  C_M_AXI_ADDR_WIDTH  bytes to read
i_rd_byte_valid  in  1  request valid
o_rd_byte_ready  out  1  request accept
o_rd_queue_finish  out  1  one-cycle done pulse
o_m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  AR address
o_m_axi_arlen  out  8  AR beats-1
o_m_axi_arvalid  out  1  AR valid
i_m_axi_arready  in  1  AR ready
i_m_axi_rdata  in  C_M_AXI_DATA_WIDTH  R data
i_m_axi_rvalid  in  1  R valid
i_m_axi_rlast  in  1  R last
o_m_axi_rready  out  1  R ready
o_rd_data  out  C_M_AXI_DATA_WIDTH  read data
o_rd_data_valid  out  1  data valid
o_rd_data_last  out  1  last beat of request
o_rd_data_flag  out  1  latched i_rd_flag
o_rd_data_queue  out  P_DDR_LOCAL_QUEUE  latched queue
i_rd_data_ready  in  1  downstream ready
o_err  out  1  sticky illegal-queue flag

Function
REQ-003 SHALL use FSM IDLE -> ADDR -> DATA -> (ADDR | DONE) -> IDLE; one outstanding burst.
REQ-004 SHALL drive o_rd_byte_ready=1 only in IDLE; request accepted when valid&ready; queue, byte count, flag latched that cycle.
REQ-005 SHALL compute beats = ceil(i_rd_byte/64); remaining-beat counter decrements per accepted R beat.
REQ-006 SHALL keep per-queue read offset (0..P_QUEUE_REGION-1); address = queue*P_QUEUE_REGION + offset; offset advances 64 per beat and wraps to 0 at region end.
REQ-007 SHALL size each burst = min(remaining, P_MAX_BURST, beats to next 4 KB boundary, beats to region end); arlen = size-1.
REQ-008 SHALL assert arvalid in ADDR, hold address/len stable until arready, then enter DATA.
REQ-009 SHALL pass R combinationally: o_m_axi_rready=i_rd_data_ready in DATA, o_rd_data_valid=i_m_axi_rvalid in DATA, zero elsewhere.
REQ-010 SHALL assert o_rd_data_last on final beat of final burst only.
REQ-011 SHALL, on beat accepted with rlast: go ADDR if remaining>0 else DONE.
REQ-012 SHALL pulse o_rd_queue_finish for exactly one cycle in DONE (cycle after final beat); return to IDLE next cycle.
REQ-013 SHALL, for i_rd_byte=0, go IDLE->DONE directly: no AR, finish next cycle.
REQ-014 SHALL, for queue >= P_QUEUE_NUM, set o_err, issue no AR, go to DONE.
REQ-015 SHALL ignore i_rd_byte_valid outside IDLE.

Reset
REQ-016 SHALL, on i_rst_n low (any time, incl. mid-burst), immediately force IDLE, all offsets/counters to 0, every output to 0 (o_rd_byte_ready becomes 1 on first clock after release).

Structure
REQ-017 SHALL place FSM state encodings, beat size (64), 4 KB constant in shared package rd_ddr_pkg.
REQ-018 SHALL isolate burst-size computation (REQ-007) in sub-module rd_ddr_burst_split.

Verification
REQ-019 queue 2, 256 B, offsets 0 -> one AR addr 0x0010_0000 arlen 3; 4 beats, last on 4th; finish 1 cycle after; queue 2 offset 0x100.
REQ-020 queue 0, 5000 B -> 79 beats: AR 0x0 arlen 63, then 0x1000 arlen 14; single finish.
REQ-021 queue 1 offset 0x7FFC0, 128 B -> AR 0x000F_FFC0 arlen 0, then 0x0008_0000 arlen 0; offset 0x40.
REQ-022 0 B request -> accepted, no arvalid, finish pulse next cycle.
REQ-023 i_rd_data_ready low 10 cycles mid-burst -> rready low, beats delivered in order, none lost/duplicated.
REQ-024 reset low during DATA -> outputs 0 same cycle, offsets 0; queue 5, 64 B request after release -> AR 0x0028_0000 arlen 0.
